// File: rtl/in3072_out1536.sv
// in3072_out1536: splits each wide input word into two narrow output beats
// (low half first, then high half). A word flagged thalf yields only its low
// half. Packet end, weight-switch and a per-packet beat counter travel with
// the data.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// tvalid & tready are both 1. The source holds tvalid and its payload until
// that edge. m_axis_tdata/tlast are held stable while tvalid & ~tready.
module in3072_out1536 #(
  parameter int DATA_IN_W  = 3072,
  parameter int DATA_OUT_W = 1536
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_IN_W-1:0]  s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_thalf,
  input  logic                  weight_switch,
  output logic [DATA_OUT_W-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  weight_switch_out,
  output logic [15:0]           beat_cnt,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // holding buffer empty
    LO   = 2'd1,  // presenting the low half of the buffer
    HI   = 2'd2   // presenting the high half of the buffer
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_IN_W-1:0]   buf_data_q, buf_data_d;
  logic                   buf_last_q, buf_last_d;
  logic                   buf_half_q, buf_half_d;
  logic                   buf_ws_q, buf_ws_d;
  logic [15:0]            beat_cnt_q, beat_cnt_d;

  logic last_beat;
  logic in_hs;
  logic out_hs;

  // The beat now on the output is the final one of the buffered word.
  assign last_beat = (state_q == HI) | ((state_q == LO) & buf_half_q);

  // Accept a new word when empty, or when the final beat drains this cycle.
  assign s_axis_tready = ~rst & ((state_q == IDLE) | (last_beat & m_axis_tready));
  assign in_hs         = s_axis_tvalid & s_axis_tready;

  assign m_axis_tvalid = (state_q != IDLE);
  assign out_hs        = m_axis_tvalid & m_axis_tready;

  // The buffer is cleared by reset, so the data output reads zero then.
  assign m_axis_tdata      = (state_q == HI) ? buf_data_q[DATA_IN_W-1:DATA_OUT_W]
                                             : buf_data_q[DATA_OUT_W-1:0];
  assign m_axis_tlast      = last_beat & buf_last_q;
  assign weight_switch_out = out_hs & last_beat & buf_ws_q;
  assign beat_cnt          = beat_cnt_q;
  assign dbg_state         = state_q;

  // Next state: advance only on output handshakes, reload on input handshakes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_hs) state_d = LO;
      end
      LO, HI: begin
        if (out_hs) begin
          if (!last_beat)  state_d = HI;
          else if (in_hs)  state_d = LO;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding buffer loads the whole word and its side flags on input handshake.
  always_comb begin
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    buf_half_d = buf_half_q;
    buf_ws_d   = buf_ws_q;
    if (in_hs) begin
      buf_data_d = s_axis_tdata;
      buf_last_d = s_axis_tlast;
      buf_half_d = s_axis_thalf;
      buf_ws_d   = weight_switch;
    end
  end

  // Beat counter: clears on the tlast beat, otherwise counts up and saturates.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (out_hs) begin
      if (m_axis_tlast)                beat_cnt_d = 16'd0;
      else if (beat_cnt_q != 16'hFFFF) beat_cnt_d = beat_cnt_q + 16'd1;
    end
  end

  // State, buffer and counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_data_q <= '0;
      buf_last_q <= 1'b0;
      buf_half_q <= 1'b0;
      buf_ws_q   <= 1'b0;
      beat_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
      buf_half_q <= buf_half_d;
      buf_ws_q   <= buf_ws_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_in3072_out1536.sv
// Testbench for in3072_out1536: directed scenarios followed by a long random
// run, all output beats checked by a queue-based scoreboard.
module tb_in3072_out1536;

  localparam int DIN  = 3072;
  localparam int DOUT = 1536;
  localparam int NUM_RAND_WORDS = 10000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- DUT ----------------
  logic [DIN-1:0]  s_axis_tdata;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic            s_axis_tlast;
  logic            s_axis_thalf;
  logic            weight_switch;
  logic [DOUT-1:0] m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic            weight_switch_out;
  logic [15:0]     beat_cnt;
  logic [1:0]      dbg_state;

  in3072_out1536 #(.DATA_IN_W(DIN), .DATA_OUT_W(DOUT)) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_thalf      (s_axis_thalf),
    .weight_switch     (weight_switch),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .weight_switch_out (weight_switch_out),
    .beat_cnt          (beat_cnt),
    .dbg_state         (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  // Each entry: {weight_switch_out, tlast, data} expected for one output beat.
  logic [DOUT+1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cnt_model = 0;   // expected beat_cnt before the next beat
  int in_ws_cnt = 0;   // accepted words carrying weight_switch
  int ws_seen = 0;     // weight_switch_out pulses observed
  bit rand_ready = 1'b0;

  function automatic void chk(input string name, input logic [DOUT-1:0] act,
                              input logic [DOUT-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (low 64 bits) at cycle %0d",
               name, act[63:0], exp[63:0], cyc);
    end
  endfunction

  function automatic logic [DIN-1:0] rand_word();
    logic [DIN-1:0] w;
    for (int i = 0; i < DIN / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  // Present a word and hold it until accepted; record the expected beats.
  task automatic send_word(input logic [DIN-1:0] d, input logic l, input logic h,
                           input logic w, output int acc_cyc);
    int guard;
    guard = 0;
    acc_cyc = -1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_thalf  = h;
    weight_switch = w;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && guard < 2000) begin
      guard++;
      @(negedge clk);
    end
    if (!s_axis_tready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: s_axis_tready stayed 0 required 1 at cycle %0d", cyc);
    end else begin
      if (h) begin
        exp_q.push_back({w, l, d[DOUT-1:0]});
      end else begin
        exp_q.push_back({1'b0, 1'b0, d[DOUT-1:0]});
        exp_q.push_back({w, l, d[DIN-1:DOUT]});
      end
      if (w) in_ws_cnt++;
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  // Idle cycles with junk on the data/side inputs, which must be ignored.
  task automatic idle_cycles(input int n);
    repeat (n) begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = rand_word();
      s_axis_tlast  = 1'($urandom_range(0, 1));
      s_axis_thalf  = 1'($urandom_range(0, 1));
      weight_switch = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) for every expected beat to come out.
  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20000) begin
      guard++;
      @(posedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats still pending required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- random downstream backpressure ----------------
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor ----------------
  initial forever begin
    logic [DOUT+1:0] e;
    @(negedge clk);
    if (weight_switch_out) ws_seen++;
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL extra_beat: data 0x%0h with no beat expected at cycle %0d",
                 m_axis_tdata[63:0], cyc);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", m_axis_tdata, e[DOUT-1:0]);
        chk("beat_tlast", DOUT'(m_axis_tlast), DOUT'(e[DOUT]));
        chk("beat_ws_out", DOUT'(weight_switch_out), DOUT'(e[DOUT+1]));
        chk("beat_cnt", DOUT'(beat_cnt), DOUT'(cnt_model));
        if (e[DOUT])                cnt_model = 0;
        else if (cnt_model < 65535) cnt_model++;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int acc[4];
    int a;
    logic [DIN-1:0] d;
    logic [DOUT-1:0] lo5;
    logic [DOUT-1:0] hia;

    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_thalf  = 1'b0;
    weight_switch = 1'b0;
    m_axis_tready = 1'b1;

    // Reset values (downstream ready, input valid with junk to prove masking).
    repeat (3) @(posedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = rand_word();
    #1;
    chk("rst_m_tvalid", DOUT'(m_axis_tvalid), '0);
    chk("rst_s_tready", DOUT'(s_axis_tready), '0);
    chk("rst_m_tlast", DOUT'(m_axis_tlast), '0);
    chk("rst_m_tdata", m_axis_tdata, '0);
    chk("rst_ws_out", DOUT'(weight_switch_out), '0);
    chk("rst_beat_cnt", DOUT'(beat_cnt), '0);
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_tready", DOUT'(s_axis_tready), DOUT'(1));
    @(posedge clk);
    #1;

    // Single word {A..A, 5..5} with tlast.
    lo5 = {(DOUT/4){4'h5}};
    hia = {(DOUT/4){4'hA}};
    send_word({hia, lo5}, 1'b1, 1'b0, 1'b0, a);
    @(posedge clk);
    #1;
    chk("single_cnt_after_lo", DOUT'(beat_cnt), DOUT'(1));
    @(posedge clk);
    #1;
    chk("single_cnt_after_hi", DOUT'(beat_cnt), '0);
    chk("single_idle_tvalid", DOUT'(m_axis_tvalid), '0);
    drain();

    // Four back-to-back full words: one acceptance every second cycle.
    for (int i = 0; i < 4; i++)
      send_word(rand_word(), 1'(i == 3), 1'b0, 1'b0, acc[i]);
    for (int i = 1; i < 4; i++)
      chk("b2b_accept_spacing", DOUT'(acc[i] - acc[i-1]), DOUT'(2));
    drain();

    // Half word with tlast and weight switch: one beat, pulse in that cycle.
    d = rand_word();
    send_word(d, 1'b1, 1'b1, 1'b1, a);
    @(negedge clk);
    chk("half_ws_pulse", DOUT'(weight_switch_out), DOUT'(1));
    chk("half_tlast", DOUT'(m_axis_tlast), DOUT'(1));
    chk("half_data", m_axis_tdata, d[DOUT-1:0]);
    @(posedge clk);
    #1;
    chk("half_single_beat", DOUT'(m_axis_tvalid), '0);
    drain();

    // Backpressure in LO for 5 cycles: everything held.
    m_axis_tready = 1'b0;
    d = rand_word();
    send_word(d, 1'b1, 1'b0, 1'b0, a);
    repeat (5) begin
      @(negedge clk);
      chk("bp_tvalid", DOUT'(m_axis_tvalid), DOUT'(1));
      chk("bp_tdata", m_axis_tdata, d[DOUT-1:0]);
      chk("bp_s_tready", DOUT'(s_axis_tready), '0);
      chk("bp_tlast", DOUT'(m_axis_tlast), '0);
    end
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    drain();

    // Reset pulsed while presenting the high half.
    m_axis_tready = 1'b0;
    send_word(rand_word(), 1'b1, 1'b0, 1'b0, a);
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    m_axis_tready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", DOUT'(m_axis_tvalid), '0);
    chk("midrst_beat_cnt", DOUT'(beat_cnt), '0);
    chk("midrst_s_tready", DOUT'(s_axis_tready), '0);
    exp_q.delete();
    cnt_model = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge clk);
    chk("midrst_release_s_tready", DOUT'(s_axis_tready), DOUT'(1));
    chk("midrst_no_partial", DOUT'(m_axis_tvalid), '0);
    @(posedge clk);
    #1;
    send_word(rand_word(), 1'b1, 1'b0, 1'b0, a);
    drain();

    // Random traffic with random downstream backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < NUM_RAND_WORDS; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
      send_word(rand_word(), 1'($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0), a);
    end
    drain();
    rand_ready = 1'b0;

    chk("ws_pulse_count", DOUT'(ws_seen), DOUT'(in_ws_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
